// File: rtl/cpu_retire_align.sv
// cpu_retire_align: in-order retire queue between the commit stage and the
// trace consumers. Commit records are queued in program order. A load waits
// for its (in-order) bus response, and then one complete record per
// instruction is emitted as a single-cycle pulse on the trc_* bus.
module cpu_retire_align #(
   parameter int DEPTH = 4,
   parameter int DCW   = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              cmt_valid,
   output logic              cmt_ready,
   input  logic [31:0]       cmt_pc,
   input  logic [31:0]       cmt_inst,
   input  logic [1:0]        cmt_prv,
   input  logic              cmt_rd_wr,
   input  logic [4:0]        cmt_rd_addr,
   input  logic [31:0]       cmt_rd_data,
   input  logic              cmt_mem_req,
   input  logic              cmt_mem_wr,
   input  logic [31:0]       cmt_mem_addr,
   input  logic [3:0]        cmt_mem_byte,
   input  logic [31:0]       cmt_mem_wdata,
   input  logic              ld_rvalid,
   input  logic [31:0]       ld_rdata,
   input  logic [31:0]       ld_rd_data,
   output logic              trc_valid,
   output logic [31:0]       trc_pc,
   output logic [31:0]       trc_inst,
   output logic [31:0]       trc_rd_data,
   output logic [31:0]       trc_mem_addr,
   output logic [31:0]       trc_mem_rdata,
   output logic [31:0]       trc_mem_wdata,
   output logic [1:0]        trc_prv,
   output logic              trc_rd_wr,
   output logic              trc_mem_req,
   output logic              trc_mem_wr,
   output logic [4:0]        trc_rd_addr,
   output logic [3:0]        trc_mem_byte,
   output logic [DCW-1:0]    drop_cnt,
   output logic              resp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
   localparam logic [DCW-1:0] DROP_MAX = {DCW{1'b1}};

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  prv;
      logic        rd_wr;
      logic [4:0]  rd_addr;
      logic [31:0] rd_data;
      logic        mem_req;
      logic        mem_wr;
      logic [31:0] mem_addr;
      logic [3:0]  mem_byte;
      logic [31:0] mem_wdata;
      logic [31:0] mem_rdata;
   } rec_t;

   // A record waits for a response only when it reads memory.
   function automatic logic rec_is_load(input rec_t r);
      return r.mem_req & ~r.mem_wr;
   endfunction

   // Queue storage; contents of unoccupied slots are never observed.
   rec_t             slot_q [DEPTH];
   logic [DEPTH-1:0] done_q;

   logic [AW-1:0]  head_q, head_d;
   logic [AW-1:0]  tail_q, tail_d;
   logic [AW-1:0]  lp_q, lp_d;
   logic [AW-1:0]  lp_next_s;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  pend_q, pend_d;
   logic [CW-1:0]  pend_left_s;
   logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
   logic           resp_err_q, resp_err_d;

   logic           ready_s;
   logic           push_s;
   logic           pop_s;
   logic           drop_s;
   logic           cmt_load_s;
   logic           resp_take_s;
   logic           resp_orphan_s;
   rec_t           push_rec_s;
   rec_t           head_rec_s;
   rec_t           trc_d;
   rec_t           trc_q;
   logic           trc_valid_q;

   assign cmt_load_s    = cmt_mem_req & ~cmt_mem_wr;
   assign ready_s       = (count_q < DEPTH_C);
   assign push_s        = cmt_valid & ready_s;
   assign drop_s        = cmt_valid & ~ready_s;
   assign pop_s         = (count_q != CNT_ZERO) & done_q[head_q];
   assign resp_take_s   = ld_rvalid & (pend_q != CNT_ZERO);
   assign resp_orphan_s = ld_rvalid & (pend_q == CNT_ZERO);
   assign head_rec_s    = slot_q[head_q];

   // Build the record to push; loads start with no data, filled on response.
   always_comb begin
      push_rec_s           = '0;
      push_rec_s.pc        = cmt_pc;
      push_rec_s.inst      = cmt_inst;
      push_rec_s.prv       = cmt_prv;
      push_rec_s.rd_wr     = cmt_rd_wr;
      push_rec_s.rd_addr   = cmt_rd_addr;
      push_rec_s.rd_data   = cmt_load_s ? 32'h0000_0000 : cmt_rd_data;
      push_rec_s.mem_req   = cmt_mem_req;
      push_rec_s.mem_wr    = cmt_mem_wr;
      push_rec_s.mem_addr  = cmt_mem_addr;
      push_rec_s.mem_byte  = cmt_mem_byte;
      push_rec_s.mem_wdata = cmt_mem_wdata;
      push_rec_s.mem_rdata = 32'h0000_0000;
   end

   // Find the next incomplete load younger than lp among occupied slots.
   always_comb begin : lp_scan
      logic [AW-1:0] idx;
      logic [AW-1:0] off;
      logic          hit;
      logic          found;
      lp_next_s = lp_q;
      found     = 1'b0;
      idx       = lp_q;
      off       = {AW{1'b0}};
      hit       = 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
         idx       = lp_q + AW'(i);
         off       = idx - head_q;
         hit       = ({1'b0, off} < count_q) & rec_is_load(slot_q[idx]) & ~done_q[idx];
         lp_next_s = (hit & ~found) ? idx : lp_next_s;
         found     = found | hit;
      end
   end

   // Pointer, occupancy and status next-state.
   always_comb begin
      head_d      = pop_s  ? head_q + AW'(1'b1) : head_q;
      tail_d      = push_s ? tail_q + AW'(1'b1) : tail_q;
      count_d     = count_q + CW'(push_s) - CW'(pop_s);
      pend_left_s = pend_q - CW'(resp_take_s);
      pend_d      = pend_left_s + CW'(push_s & cmt_load_s);
      if (resp_take_s && (pend_left_s != CNT_ZERO)) begin
         lp_d = lp_next_s;
      end else if (push_s && cmt_load_s && (pend_left_s == CNT_ZERO)) begin
         lp_d = tail_q;
      end else begin
         lp_d = lp_q;
      end
      if (drop_s && (drop_cnt_q != DROP_MAX)) begin
         drop_cnt_d = drop_cnt_q + DCW'(1'b1);
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
      resp_err_d = resp_err_q | resp_orphan_s;
   end

   // Next trace record: head entry with a write to x0 reported as zero.
   always_comb begin
      trc_d = trc_q;
      if (pop_s) begin
         trc_d = head_rec_s;
         if (head_rec_s.rd_wr && (head_rec_s.rd_addr == 5'd0)) begin
            trc_d.rd_data = 32'h0000_0000;
         end else begin
            trc_d.rd_data = head_rec_s.rd_data;
         end
      end else begin
         trc_d = trc_q;
      end
   end

   // Queue slot writes: push at tail, load response completes slot at lp.
   always_ff @(posedge clk) begin
      if (push_s) begin
         slot_q[tail_q] <= push_rec_s;
         done_q[tail_q] <= ~cmt_load_s;
      end
      if (resp_take_s) begin
         slot_q[lp_q].mem_rdata <= ld_rdata;
         if (slot_q[lp_q].rd_wr) begin
            slot_q[lp_q].rd_data <= ld_rd_data;
         end
         done_q[lp_q] <= 1'b1;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head_q     <= {AW{1'b0}};
         tail_q     <= {AW{1'b0}};
         lp_q       <= {AW{1'b0}};
         count_q    <= {CW{1'b0}};
         pend_q     <= {CW{1'b0}};
         drop_cnt_q <= {DCW{1'b0}};
         resp_err_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         lp_q       <= lp_d;
         count_q    <= count_d;
         pend_q     <= pend_d;
         drop_cnt_q <= drop_cnt_d;
         resp_err_q <= resp_err_d;
      end
   end

   // Trace output registers: one-cycle valid pulse, data held between pops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trc_valid_q <= 1'b0;
         trc_q       <= '0;
      end else begin
         trc_valid_q <= pop_s;
         trc_q       <= trc_d;
      end
   end

   assign cmt_ready     = ready_s;
   assign trc_valid     = trc_valid_q;
   assign trc_pc        = trc_q.pc;
   assign trc_inst      = trc_q.inst;
   assign trc_prv       = trc_q.prv;
   assign trc_rd_wr     = trc_q.rd_wr;
   assign trc_rd_addr   = trc_q.rd_addr;
   assign trc_rd_data   = trc_q.rd_data;
   assign trc_mem_req   = trc_q.mem_req;
   assign trc_mem_wr    = trc_q.mem_wr;
   assign trc_mem_addr  = trc_q.mem_addr;
   assign trc_mem_byte  = trc_q.mem_byte;
   assign trc_mem_wdata = trc_q.mem_wdata;
   assign trc_mem_rdata = trc_q.mem_rdata;
   assign drop_cnt      = drop_cnt_q;
   assign resp_err      = resp_err_q;

endmodule

// File: doc/cpu_retire_align.md
Name: cpu_retire_align

Overview:
- Sits between the CPU commit stage and the instruction tracer and debug trace consumers.
- The commit stage presents one record per retired instruction. For loads, the bus read data and the writeback value return later than the commit.
- This block queues commit records in order and waits for each load's response. It then emits one complete, time-ordered retire record per instruction on the trc_* bus, which matches the tracer's input set.
- The output has no backpressure: trc_valid is a single-cycle pulse per record.

Parameters:
- DEPTH, 4, number of queued records; power of two, minimum 2.
- DCW, 8, width of the drop counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cmt_valid  in  1  commit record present this cycle
- cmt_ready  out  1  queue can accept a record
- cmt_pc  in  32  retired PC
- cmt_inst  in  32  instruction word
- cmt_prv  in  2  privilege level
- cmt_rd_wr  in  1  rd written
- cmt_rd_addr  in  5  rd index
- cmt_rd_data  in  32  rd value; ignored for loads
- cmt_mem_req  in  1  memory access
- cmt_mem_wr  in  1  1 = store
- cmt_mem_addr  in  32  access address
- cmt_mem_byte  in  4  byte enables
- cmt_mem_wdata  in  32  store data
- ld_rvalid  in  1  load response; responses arrive in load order
- ld_rdata  in  32  raw bus read data
- ld_rd_data  in  32  extended writeback value
- trc_valid  out  1  one-cycle record pulse
- trc_pc, trc_inst, trc_rd_data, trc_mem_addr, trc_mem_rdata, trc_mem_wdata  out  32 each  record fields
- trc_prv  out  2
- trc_rd_wr, trc_mem_req, trc_mem_wr  out  1 each
- trc_rd_addr  out  5
- trc_mem_byte  out  4
- drop_cnt  out  DCW  count of records lost to overflow; saturates
- resp_err  out  1  sticky flag: a load response arrived with no pending load

Behaviour:
- Reset, asynchronous on rstn low: all pointers and the count go to 0. All trc_* outputs, drop_cnt and resp_err go to 0. Queue contents are don't-care and are never emitted.
- A record is a load when cmt_mem_req & ~cmt_mem_wr. A load is pushed incomplete. All other records are pushed complete, with mem_rdata=0.
- cmt_ready = (count < DEPTH), taken from registered state only. A pop in the same cycle does not free a slot until the next cycle.
- Push happens on cmt_valid & cmt_ready. If cmt_valid & ~cmt_ready, the record is dropped and drop_cnt increments, holding at 2^DCW-1. The stage is never stalled.
- The load pointer lp tracks the oldest incomplete load entry.
- On ld_rvalid with at least one incomplete load queued, the entry at lp captures ld_rdata into mem_rdata. If rd_wr is set, it also captures ld_rd_data into rd_data. The entry is marked complete and lp advances to the next queued load.
- On ld_rvalid with no incomplete load queued, the response is ignored and resp_err is set to 1 until reset.
- A load pushed and answered in the same cycle: the response belongs to an older pending load if one exists. Otherwise it is treated as having no target, which sets resp_err. A response must lag its commit by at least one cycle.
- Pop: when the head entry is complete at the start of a cycle, the next edge drives trc_* from the head with trc_valid=1 and advances the head. Otherwise trc_valid=0 and the trc_* data fields hold their last values.
  - At most one pop per cycle.
  - Strict program order: a younger complete record waits behind an older incomplete load.
- Latency:
  - Non-load committed at edge N: trc_valid at edge N+1 when the queue was empty.
  - Load whose response is taken at edge M while it is at the head: trc_valid at edge M+1.
- When rd_wr=1 and rd_addr=0, trc_rd_data is forced to 0.
- Push and pop may occur in the same cycle. In that case count is unchanged and pointers wrap modulo DEPTH.

Test Plan:
- Reset, then one ALU commit (pc=0x100, rd x5=0x1234) at edge 1 -> trc_valid pulse at edge 2 with trc_pc=0x100, trc_rd_data=0x1234; cmt_ready=1 throughout.
- Load (pc=0x200, rd x6) followed by an ALU op (pc=0x204); ld_rvalid 3 cycles later with ld_rdata=0xAABBCCDD, ld_rd_data=0xFFFFFFDD -> 0x200 emitted one cycle after the response with mem_rdata=0xAABBCCDD and rd_data=0xFFFFFFDD, then 0x204 one cycle after that.
- Two loads outstanding; responses 0x11 and 0x22 -> the first load carries 0x11 and the second carries 0x22, with no reordering.
- DEPTH=4, head load unanswered, 6 commits pushed -> cmt_ready=0 after 4 pushes and drop_cnt=2; after the response, 4 records drain on consecutive cycles.
- ld_rvalid with an empty queue -> resp_err=1 and stays set, no trc_valid; the next normal commit still traces correctly.
- Assert rstn low while two records are queued -> trc_valid=0 immediately; nothing from before reset is emitted afterwards.
